// File: rtl/unity_ecc_pkg.sv
// GF(2^8) constants and elaboration-time helpers shared by the unity RS encoder.
// Primitive polynomial x^8+x^6+x^4+x^3+x^2+x+1; alpha = 8'h02.
package unity_ecc_pkg;

  localparam int SYM_W = 8;
  localparam logic [8:0] PRIM_POLY = 9'h15F;
  localparam int MAX_K = 32;

  typedef logic [7:0] sym_t;

  typedef enum logic {
    ST_DATA   = 1'b0,
    ST_PARITY = 1'b1
  } enc_state_t;

  // Column exponents: the first eight match the legacy 64b->80b encoder.
  localparam logic [7:0] COL_EXP [0:MAX_K-1] = '{
    8'd25,  8'd39,  8'd63,  8'd108, 8'd141, 8'd184, 8'd215, 8'd230,
    8'd7,   8'd19,  8'd52,  8'd77,  8'd96,  8'd121, 8'd158, 8'd171,
    8'd199, 8'd206, 8'd223, 8'd241, 8'd250, 8'd3,   8'd11,  8'd33,
    8'd45,  8'd58,  8'd86,  8'd92,  8'd117, 8'd130, 8'd149, 8'd163
  };

  function automatic sym_t gf_mul(input sym_t a, input sym_t b);
    sym_t aa;
    sym_t r;
    aa = a;
    r  = 8'h00;
    for (int i = 0; i < SYM_W; i++) begin
      r  = b[i] ? (r ^ aa) : r;
      aa = aa[7] ? ((aa << 1) ^ PRIM_POLY[7:0]) : (aa << 1);
    end
    return r;
  endfunction

  function automatic sym_t gf_alpha_pow(input int e);
    sym_t r;
    r = 8'h01;
    for (int i = 0; i < e; i++) begin
      r = gf_mul(r, 8'h02);
    end
    return r;
  endfunction

endpackage

// File: rtl/unity_stream_encoder_slice.sv
// Parity contribution of one data beat: constant GF multipliers feeding an XOR tree,
// with the coefficient set chosen by the beat index.
module unity_parity_slice #(
  parameter int BEAT_SYM = 2,
  parameter int NPAR     = 2,
  parameter int K_SYM    = 8,
  localparam int NBEAT   = K_SYM / BEAT_SYM,
  localparam int CNT_W   = (NBEAT > 1) ? $clog2(NBEAT) : 1
) (
  input  logic [CNT_W-1:0]      beat_idx,
  input  logic [BEAT_SYM*8-1:0] beat_data,
  output logic [NPAR*8-1:0]     contrib
);
  import unity_ecc_pkg::*;

  function automatic logic [K_SYM*NPAR*8-1:0] build_coefs();
    logic [K_SYM*NPAR*8-1:0] c;
    c = '0;
    for (int i = 0; i < K_SYM; i++) begin
      for (int j = 0; j < NPAR; j++) begin
        c[(i*NPAR+j)*8 +: 8] = gf_alpha_pow(((j + 1) * int'(COL_EXP[i])) % 255);
      end
    end
    return c;
  endfunction

  // alpha^((j+1)*E[i]) for every symbol position i and parity row j
  localparam logic [K_SYM*NPAR*8-1:0] COEFS = build_coefs();

  // Every beat's multipliers exist; a mask keeps only the addressed beat's terms
  always_comb begin
    contrib = '0;
    for (int b = 0; b < NBEAT; b++) begin
      for (int s = 0; s < BEAT_SYM; s++) begin
        for (int j = 0; j < NPAR; j++) begin
          contrib[(NPAR-1-j)*8 +: 8] = contrib[(NPAR-1-j)*8 +: 8]
            ^ (gf_mul(beat_data[(BEAT_SYM-1-s)*8 +: 8], COEFS[((b*BEAT_SYM+s)*NPAR+j)*8 +: 8])
               & {8{beat_idx == CNT_W'(b)}});
        end
      end
    end
  end

endmodule

// File: rtl/unity_stream_encoder.sv
// Streaming systematic RS encoder: passes K_SYM data symbols through in BEAT_SYM-wide
// beats, then appends one parity beat with NPAR symbols in its upper lanes.
module unity_stream_encoder #(
  parameter int BEAT_SYM = 2,
  parameter int K_SYM    = 8,
  parameter int NPAR     = 2,
  parameter int SYM_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BEAT_SYM*SYM_W-1:0] in_data,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BEAT_SYM*SYM_W-1:0] out_data,
  output logic                      out_parity,
  output logic                      out_last
);
  import unity_ecc_pkg::*;

  localparam int NBEAT  = K_SYM / BEAT_SYM;
  localparam int CNT_W  = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam int BEAT_W = BEAT_SYM * SYM_W;
  localparam int PAR_W  = NPAR * SYM_W;
  localparam int PAD_W  = BEAT_W - PAR_W;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEAT - 1);

  if (SYM_W != 32'sd8 || K_SYM < 32'sd1 || K_SYM > MAX_K || (K_SYM % BEAT_SYM) != 32'sd0
      || NPAR < 32'sd1 || NPAR > BEAT_SYM) begin : g_bad_params
    $error("unity_stream_encoder: unsupported parameter combination");
  end

  enc_state_t       state_r;
  logic [CNT_W-1:0] beat_cnt_r;
  logic [PAR_W-1:0] acc_r;
  logic [PAR_W-1:0] par_reg_r;
  logic [PAR_W-1:0] contrib_s;
  logic [BEAT_W-1:0] par_beat_s;
  logic             out_free_s;
  logic             accept_s;

  unity_parity_slice #(
    .BEAT_SYM (BEAT_SYM),
    .NPAR     (NPAR),
    .K_SYM    (K_SYM)
  ) u_slice (
    .beat_idx  (beat_cnt_r),
    .beat_data (in_data),
    .contrib   (contrib_s)
  );

  assign out_free_s = !out_valid || out_ready;
  assign in_ready   = (state_r == ST_DATA) && out_free_s && !flush;
  assign accept_s   = in_valid && in_ready;
  assign par_beat_s = BEAT_W'(par_reg_r) << PAD_W;
  assign out_last   = out_parity;

  // Codeword FSM, parity accumulator and the single-entry output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_DATA;
      beat_cnt_r <= '0;
      acc_r      <= '0;
      par_reg_r  <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_parity <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (flush) begin
        // flush beats a pending parity load; the held output beat still drains
        state_r    <= ST_DATA;
        beat_cnt_r <= '0;
        acc_r      <= '0;
        par_reg_r  <= '0;
      end else begin
        case (state_r)
          ST_DATA: begin
            if (accept_s) begin
              out_valid  <= 1'b1;
              out_data   <= in_data;
              out_parity <= 1'b0;
              if (beat_cnt_r == LAST_BEAT) begin
                par_reg_r  <= acc_r ^ contrib_s;
                acc_r      <= '0;
                beat_cnt_r <= '0;
                state_r    <= ST_PARITY;
              end else begin
                acc_r      <= acc_r ^ contrib_s;
                beat_cnt_r <= beat_cnt_r + CNT_W'(1);
              end
            end
          end
          ST_PARITY: begin
            if (out_free_s) begin
              out_valid  <= 1'b1;
              out_data   <= par_beat_s;
              out_parity <= 1'b1;
              state_r    <= ST_DATA;
            end
          end
          default: begin
            state_r <= ST_DATA;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_unity_stream_encoder.sv
// Directed + random scoreboard bench for unity_stream_encoder (default and 4-symbol-beat builds).
module tb_unity_stream_encoder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_out_parity, a_out_last;
  logic [15:0] a_in_data, a_out_data;
  logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_out_parity, b_out_last;
  logic [31:0] b_in_data, b_out_data;

  unity_stream_encoder dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .flush(a_flush), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_parity(a_out_parity), .out_last(a_out_last));

  unity_stream_encoder #(.BEAT_SYM(4), .K_SYM(16), .NPAR(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .flush(b_flush), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_parity(b_out_parity), .out_last(b_out_last));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [32:0] qa [$];
  logic [32:0] qb [$];
  int col_e [32] = '{25, 39, 63, 108, 141, 184, 215, 230, 7, 19, 52, 77, 96, 121, 158, 171,
                     199, 206, 223, 241, 250, 3, 11, 33, 45, 58, 86, 92, 117, 130, 149, 163};
  logic [7:0] alog [255];
  int lg [256];
  logic stall_en = 1'b0;
  int stretches_done = 0;
  logic a_hold, b_hold;
  logic [15:0] a_hold_data;
  logic [31:0] b_hold_data;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent golden: log/antilog tables over 0x15F, parity rows alpha^E and alpha^2E
  function automatic logic [15:0] golden(input logic [127:0] w, input int k);
    logic [7:0] p0, p1, d;
    p0 = 8'h00;
    p1 = 8'h00;
    for (int i = 0; i < k; i++) begin
      d = w[(k-1-i)*8 +: 8];
      if (d != 8'h00) begin
        p0 ^= alog[(lg[d] + col_e[i]) % 255];
        p1 ^= alog[(lg[d] + 2 * col_e[i]) % 255];
      end
    end
    return {p0, p1};
  endfunction

  // Random out_ready stretches for the A instance while stall_en is set
  initial begin
    int len;
    len = 0;
    a_out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (len > 0) begin
        a_out_ready = 1'b0;
        len--;
      end else if (stall_en && stretches_done < 7 && $urandom_range(0, 3) == 0) begin
        a_out_ready = 1'b0;
        len = $urandom_range(0, 4);
        stretches_done++;
      end else begin
        a_out_ready = 1'b1;
      end
    end
  end

  // Output monitors: pop the scoreboard on each handshake, check holding behaviour
  always @(negedge clk) begin
    if (rst) begin
      a_hold <= 1'b0;
      b_hold <= 1'b0;
    end else begin
      if (a_hold) begin
        chk("a_hold_valid", 64'(a_out_valid), 64'd1);
        chk("a_hold_data", 64'(a_out_data), 64'(a_hold_data));
      end
      if (a_out_valid) chk("a_last_eq_parity", 64'(a_out_last), 64'(a_out_parity));
      if (a_out_valid && !a_out_ready) chk("a_in_ready_full", 64'(a_in_ready), 64'd0);
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) chk("a_extra_beat", 64'(qa.size()), 64'd1);
        else chk("a_beat", 64'({a_out_last, 16'h0000, a_out_data}), 64'(qa.pop_front()));
      end
      a_hold <= a_out_valid && !a_out_ready;
      a_hold_data <= a_out_data;
      if (b_out_valid && b_out_ready) begin
        if (qb.size() == 0) chk("b_extra_beat", 64'(qb.size()), 64'd1);
        else chk("b_beat", 64'({b_out_last, b_out_data}), 64'(qb.pop_front()));
      end
    end
  end

  task automatic send_beat_a(input logic [15:0] d, input bit push);
    bit ok;
    int n;
    if (push) qa.push_back({1'b0, 16'h0000, d});
    a_in_valid = 1'b1;
    a_in_data = d;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = a_in_ready;
      n++;
      @(posedge clk);
      #1;
    end
    a_in_valid = 1'b0;
    if (!ok) chk("a_accept_timeout", 64'(n), 64'd0);
  endtask

  task automatic send_word_a(input logic [63:0] w, input logic [15:0] par, output int t0);
    t0 = 0;
    for (int b = 0; b < 4; b++) begin
      send_beat_a(w[(3-b)*16 +: 16], 1'b1);
      if (b == 0) t0 = cyc;
    end
    qa.push_back({1'b1, 16'h0000, par});
  endtask

  task automatic send_word_b(input logic [127:0] w, input logic [31:0] par);
    bit ok;
    int n;
    for (int b = 0; b < 4; b++) begin
      qb.push_back({1'b0, w[(3-b)*32 +: 32]});
      b_in_valid = 1'b1;
      b_in_data = w[(3-b)*32 +: 32];
      ok = 1'b0;
      n = 0;
      while (!ok && n < 100) begin
        @(negedge clk);
        ok = b_in_ready;
        n++;
        @(posedge clk);
        #1;
      end
      b_in_valid = 1'b0;
      if (!ok) chk("b_accept_timeout", 64'(n), 64'd0);
    end
    qb.push_back({1'b1, par});
  endtask

  task automatic pulse_flush_a();
    a_flush = 1'b1;
    @(negedge clk);
    chk("a_flush_in_ready", 64'(a_in_ready), 64'd0);
    @(posedge clk);
    #1;
    a_flush = 1'b0;
  endtask

  initial begin
    logic [7:0] x;
    logic [63:0] w;
    logic [127:0] wb;
    int t1, t2, t3, n;

    x = 8'h01;
    for (int i = 0; i < 255; i++) begin
      alog[i] = x;
      lg[x] = i;
      x = x[7] ? ((x << 1) ^ 8'h5F) : (x << 1);
    end

    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = 16'h0; a_flush = 1'b0;
    b_in_valid = 1'b0; b_in_data = 32'h0; b_flush = 1'b0; b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_a_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_a_out_data", 64'(a_out_data), 64'd0);
    chk("rst_a_out_parity", 64'(a_out_parity), 64'd0);
    chk("rst_a_out_last", 64'(a_out_last), 64'd0);
    chk("rst_a_in_ready", 64'(a_in_ready), 64'd1);
    chk("rst_b_out_valid", 64'(b_out_valid), 64'd0);
    chk("rst_b_in_ready", 64'(b_in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Directed words: zero, single symbols, linearity, counting pattern
    send_word_a(64'h0, 16'h0000, t1);
    send_word_a(64'h0100_0000_0000_0000, 16'hE324, t1);
    send_word_a(64'h0000_0000_0000_0001, 16'h7EA4, t1);
    send_word_a(64'h0100_0000_0000_0001, 16'h9D80, t1);
    w = 64'h0102_0304_0506_0708;
    send_word_a(w, golden({64'h0, w}, 8), t1);

    // Back-to-back codewords: one codeword every K/BEAT+1 = 5 cycles
    w = {$urandom, $urandom}; send_word_a(w, golden({64'h0, w}, 8), t1);
    w = {$urandom, $urandom}; send_word_a(w, golden({64'h0, w}, 8), t2);
    w = {$urandom, $urandom}; send_word_a(w, golden({64'h0, w}, 8), t3);
    chk("a_cw_period_1", 64'(t2 - t1), 64'd5);
    chk("a_cw_period_2", 64'(t3 - t2), 64'd5);

    for (int i = 0; i < 2000; i++) begin
      w = {$urandom, $urandom};
      send_word_a(w, golden({64'h0, w}, 8), t1);
    end

    // Back-pressure: seven random out_ready stretches across codewords
    stall_en = 1'b1;
    n = 0;
    while (stretches_done < 7 && n < 60) begin
      w = {$urandom, $urandom};
      send_word_a(w, golden({64'h0, w}, 8), t1);
      n++;
    end
    stall_en = 1'b0;
    chk("a_stall_stretches", 64'(stretches_done), 64'd7);
    repeat (8) @(posedge clk);
    #1;

    // Flush after two beats: those beats drain, the next word is encoded alone
    w = {$urandom, $urandom};
    send_beat_a(w[63:48], 1'b1);
    send_beat_a(w[47:32], 1'b1);
    pulse_flush_a();
    w = 64'h0100_0000_0000_0000;
    send_word_a(w, 16'hE324, t1);

    // Flush coinciding with the parity load: no parity beat for that word
    w = {$urandom, $urandom};
    for (int b = 0; b < 4; b++) send_beat_a(w[(3-b)*16 +: 16], 1'b1);
    pulse_flush_a();
    w = {$urandom, $urandom};
    send_word_a(w, golden({64'h0, w}, 8), t1);
    repeat (8) @(posedge clk);
    #1;

    // Async reset after one beat: output drops at once, partial word discarded
    w = {$urandom, $urandom};
    send_beat_a(w[63:48], 1'b0);
    rst = 1'b1;
    #1;
    chk("a_rst_async_out_valid", 64'(a_out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    w = 64'h0000_0000_0000_0001;
    send_word_a(w, 16'h7EA4, t1);
    w = {$urandom, $urandom};
    send_word_a(w, golden({64'h0, w}, 8), t1);

    // Four-symbol beats, K=16: parity in the upper half, lower half zero
    wb = 128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10;
    send_word_b(wb, {golden(wb, 16), 16'h0000});
    for (int i = 0; i < 40; i++) begin
      wb = {$urandom, $urandom, $urandom, $urandom};
      send_word_b(wb, {golden(wb, 16), 16'h0000});
    end

    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_a", 64'(qa.size()), 64'd0);
    chk("drain_b", 64'(qb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
